// File: rtl/decoder_pkg.sv
// Shared types and constants for the one-hot decoder / scanner.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Purely combinational binary index to one-hot decode.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      idx_i,
  output logic [2**SEL_W-1:0]   onehot_o
);

  // Set exactly the bit addressed by idx_i.
  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready request
// port and an auto-scan mode that walks the active bit with a dwell time.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 2**SEL_W,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               hold,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  state_e             state_q;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, dwell_q;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_valid_q, wrap_q;
  logic               accept, adv;

  // Ready is a pure decode of the state flop so it never depends on in_valid.
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  // Next index: load on accept, step on dwell expiry; otherwise hold.
  // Dropping mode in SCAN takes priority over hold and advance.
  always_comb begin
    idx_d = idx_q;
    adv   = 1'b0;
    if (state_q == IDLE) begin
      if (in_valid) idx_d = sel;
    end else if (mode == MODE_SCAN && !hold && cnt_q == dwell_q) begin
      adv   = 1'b1;
      idx_d = idx_q + 1'b1;
    end
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx_i    (idx_d),
    .onehot_o (out_d)
  );

  // FSM, index, dwell counter and registered outputs. out_q always mirrors
  // the decoded idx_q, so holding the index holds the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      dwell_q     <= '0;
      out_q       <= OUT_W'(1);
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= accept;
      wrap_q      <= adv && (idx_q == IDX_MAX);
      case (state_q)
        IDLE: begin
          if (accept && mode == MODE_SCAN) begin
            state_q <= SCAN;
            dwell_q <= dwell;
            cnt_q   <= '0;
          end
        end
        SCAN: begin
          if (mode == MODE_DIRECT) state_q <= IDLE;
          else if (!hold)          cnt_q   <= adv ? '0 : cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed-vector bench for decoder_scan at SEL_W = 3 (full suite),
// plus short direct/scan/wrap checks at SEL_W = 1 and SEL_W = 4.
module tb_decoder_scan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // SEL_W = 3 instance
  logic       iv3, ir3, md3, hd3, ov3, wr3;
  logic [2:0] sl3;
  logic [7:0] dw3, o3;
  // SEL_W = 1 instance
  logic       iv1, ir1, md1, hd1, ov1, wr1;
  logic [0:0] sl1;
  logic [7:0] dw1;
  logic [1:0] o1;
  // SEL_W = 4 instance
  logic        iv4, ir4, md4, hd4, ov4, wr4;
  logic [3:0]  sl4;
  logic [7:0]  dw4;
  logic [15:0] o4;

  decoder_scan #(.SEL_W(3)) d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .mode(md3),
    .sel(sl3), .dwell(dw3), .hold(hd3), .out(o3), .out_valid(ov3), .wrap(wr3));
  decoder_scan #(.SEL_W(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .mode(md1),
    .sel(sl1), .dwell(dw1), .hold(hd1), .out(o1), .out_valid(ov1), .wrap(wr1));
  decoder_scan #(.SEL_W(4)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .mode(md4),
    .sel(sl4), .dwell(dw4), .hold(hd4), .out(o4), .out_valid(ov4), .wrap(wr4));

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Step one clock and settle 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {iv3, md3, hd3, sl3, dw3} = '0;
    {iv1, md1, hd1, sl1, dw1} = '0;
    {iv4, md4, hd4, sl4, dw4} = '0;
    #12;
    chk("rst out",       32'(o3),  32'h01);
    chk("rst in_ready",  32'(ir3), 32'h1);
    chk("rst out_valid", 32'(ov3), 32'h0);
    chk("rst wrap",      32'(wr3), 32'h0);
    rst_n = 1'b1;
    step();
    chk("idle in_ready", 32'(ir3), 32'h1);

    // Single direct request, sel = 5
    iv3 = 1'b1; md3 = 1'b0; sl3 = 3'd5;
    step();
    chk("dir5 out",   32'(o3),  32'h20);
    chk("dir5 ovld",  32'(ov3), 32'h1);
    iv3 = 1'b0;
    step();
    chk("dir5 hold",  32'(o3),  32'h20);
    chk("dir5 pulse", 32'(ov3), 32'h0);

    // Back-to-back sweep 0..7
    for (int i = 0; i < 8; i++) begin
      iv3 = 1'b1; sl3 = 3'(i);
      step();
      chk($sformatf("sweep%0d out", i),  32'(o3),  32'h1 << i);
      chk($sformatf("sweep%0d ovld", i), 32'(ov3), 32'h1);
    end
    iv3 = 1'b0;

    // Scan from 6, dwell 2: 6,7,0,1 each for 3 cycles; wrap at 7->0
    iv3 = 1'b1; md3 = 1'b1; sl3 = 3'd6; dw3 = 8'd2;
    step();
    chk("scan6 out",   32'(o3),  32'h40);
    chk("scan6 ovld",  32'(ov3), 32'h1);
    chk("scan6 rdy",   32'(ir3), 32'h0);
    sl3 = 3'd3; // stays valid; must be ignored in SCAN
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("scan6 k%0d out", k),  32'(o3),  32'h1 << ((6 + k / 3) % 8));
      chk($sformatf("scan6 k%0d wrap", k), 32'(wr3), (k == 6) ? 32'h1 : 32'h0);
      chk($sformatf("scan6 k%0d rdy", k),  32'(ir3), 32'h0);
      chk($sformatf("scan6 k%0d ovld", k), 32'(ov3), 32'h0);
    end
    iv3 = 1'b0; md3 = 1'b0;
    step();
    chk("abort1 out", 32'(o3),  32'h02);
    chk("abort1 rdy", 32'(ir3), 32'h1);

    // Scan with dwell 0 from index 0: advance every cycle, wrap every 8
    iv3 = 1'b1; md3 = 1'b1; sl3 = 3'd0; dw3 = 8'd0;
    step();
    iv3 = 1'b0;
    chk("dw0 start", 32'(o3), 32'h01);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("dw0 k%0d out", k),  32'(o3),  32'h1 << (k % 8));
      chk($sformatf("dw0 k%0d wrap", k), 32'(wr3), (k % 8 == 0) ? 32'h1 : 32'h0);
    end
    md3 = 1'b0;
    step();

    // Hold for 4 cycles mid-dwell (scan from 2, dwell 3, counter at 2)
    iv3 = 1'b1; md3 = 1'b1; sl3 = 3'd2; dw3 = 8'd3;
    step();
    iv3 = 1'b0;
    step();
    step();
    hd3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("hold h%0d out", k), 32'(o3), 32'h04);
    end
    hd3 = 1'b0;
    step();
    chk("hold resume1", 32'(o3), 32'h04);
    step();
    chk("hold resume2", 32'(o3), 32'h08);

    // Abort at index 3, then direct sel = 1 on the next edge
    md3 = 1'b0;
    step();
    chk("abort2 out", 32'(o3),  32'h08);
    chk("abort2 rdy", 32'(ir3), 32'h1);
    iv3 = 1'b1; sl3 = 3'd1;
    step();
    iv3 = 1'b0;
    chk("restart out",  32'(o3),  32'h02);
    chk("restart ovld", 32'(ov3), 32'h1);

    // Asynchronous reset mid-scan
    iv3 = 1'b1; md3 = 1'b1; sl3 = 3'd4; dw3 = 8'd1;
    step();
    iv3 = 1'b0;
    step();
    step();
    chk("pre-rst out", 32'(o3), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out",  32'(o3),  32'h01);
    chk("arst rdy",  32'(ir3), 32'h1);
    chk("arst wrap", 32'(wr3), 32'h0);
    md3 = 1'b0;
    #3 rst_n = 1'b1;
    step();
    chk("post-rst out", 32'(o3),  32'h01);
    chk("post-rst rdy", 32'(ir3), 32'h1);

    // SEL_W = 1
    iv1 = 1'b1; md1 = 1'b0; sl1 = 1'b1;
    step();
    chk("w1 dir out",  32'(o1),  32'h2);
    chk("w1 dir ovld", 32'(ov1), 32'h1);
    md1 = 1'b1; sl1 = 1'b1; dw1 = 8'd0;
    step();
    iv1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("w1 k%0d out", k),  32'(o1),  (k % 2 == 1) ? 32'h1 : 32'h2);
      chk($sformatf("w1 k%0d wrap", k), 32'(wr1), (k % 2 == 1) ? 32'h1 : 32'h0);
    end
    md1 = 1'b0;

    // SEL_W = 4
    iv4 = 1'b1; md4 = 1'b0; sl4 = 4'd15;
    step();
    chk("w4 dir out", 32'(o4), 32'h8000);
    md4 = 1'b1; sl4 = 4'd14; dw4 = 8'd1;
    step();
    iv4 = 1'b0;
    chk("w4 scan start", 32'(o4), 32'h4000);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("w4 k%0d out", k),  32'(o4),
          (k < 2) ? 32'h4000 : (k < 4) ? 32'h8000 : 32'h0001);
      chk($sformatf("w4 k%0d wrap", k), 32'(wr4), (k == 4) ? 32'h1 : 32'h0);
    end
    md4 = 1'b0;
    step();
    chk("w4 abort rdy", 32'(ir4), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered binary-to-one-hot decoder that generalises the 3-to-8 decoder to SEL_W-to-2^SEL_W. It adds a valid/ready request port and an auto-scan mode that walks the active output bit with a programmable dwell time. It drives one-hot select lines, such as bank enables, LED/segment strobes or chip selects, from a single clock domain.

## Interface
- SEL_W, default 3: select width. Legal range 1..6.
- OUT_W, default 2**SEL_W: one-hot output width. Derived; must not be overridden.
- DWELL_W, default 8: width of the dwell-time field.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- mode  in  1  0 = direct decode, 1 = scan. Sampled at request accept and in every SCAN cycle.
- sel  in  SEL_W  index to decode (direct) or start index (scan).
- dwell  in  DWELL_W  cycles minus 1 that each index is held in scan. Latched at accept.
- hold  in  1  freezes the scan dwell counter and index. No effect outside SCAN.
- out  out  OUT_W  registered one-hot output. Exactly one bit is always set.
- out_valid  out  1  one-cycle pulse whenever out takes a new value from a request.
- wrap  out  1  one-cycle pulse when scan advances from index OUT_W-1 to 0.

## Operation
- Reset values:
  - out = 1 (index 0).
  - out_valid = 0, wrap = 0.
  - state = IDLE; in_ready = 1 once reset is released.
  - Index register = 0; dwell counter = 0.
- States: IDLE, SCAN.
  - in_ready = (state == IDLE).
  - in_ready is combinational from the state register only, never from in_valid.
- IDLE, accept with mode = 0:
  - Index <= sel; out <= 1 << sel; out_valid pulses.
  - Stay in IDLE.
- IDLE, accept with mode = 1:
  - Index <= sel; out <= 1 << sel; out_valid pulses.
  - Latch dwell; counter <= 0; go to SCAN.
- IDLE, no accept: out holds its value.
- SCAN, each cycle, evaluated in priority order:
  1. mode == 0: go to IDLE. No advance. out holds the current index.
  2. hold == 1: counter and index frozen.
  3. counter == dwell_latched: counter <= 0; index <= index + 1 modulo OUT_W; out <= decoded index. If the old index was OUT_W-1, wrap pulses.
  4. Otherwise: counter <= counter + 1.
- dwell = 0: index advances every cycle in SCAN.
- out_valid never pulses on a scan advance; it pulses only on an accepted request.
- Index arithmetic is SEL_W bits and wraps naturally. The counter is DWELL_W bits and never exceeds dwell_latched.
- in_valid while in SCAN is ignored and not accepted. Requests are not queued.
- Reset asserted mid-scan: all registers return to reset values immediately (asynchronous). The FSM restarts in IDLE.

## Timing
- Request to out: 1 cycle. out changes on the clock edge that accepts the request; out_valid is high in the following cycle.
- Scan period per index: dwell+1 cycles. A full rotation takes OUT_W*(dwell+1) cycles, excluding hold cycles.
- First advance after scan start occurs dwell+1 cycles after the accept edge.
- mode dropping to 0 in SCAN: state is IDLE after 1 edge. in_ready rises in that same cycle. A new request may be accepted on the next edge.
- All outputs are registered except in_ready, which is a decode of the state flop.

## Structure
- Package decoder_pkg:
  - state enum (IDLE, SCAN).
  - mode constants MODE_DIRECT = 0, MODE_SCAN = 1.
- Sub-module onehot_dec, parameter SEL_W: purely combinational index to one-hot decode. Instantiated once, feeding the out register's next-state.
- Top level contains the FSM, index register, dwell counter and output registers.

## Test plan
- Reset, then direct decode:
  - Check reset values: out = 8'b0000_0001, in_ready = 1.
  - Apply sel = 5, mode = 0: out = 8'b0010_0000 after 1 edge, one out_valid pulse.
  - Sweep sel = 0..7 back-to-back: each out is correct and out_valid is high every cycle.
- Scan, sel = 6, dwell = 2:
  - out walks bit 6 → 7 → 0 → 1, each held 3 cycles.
  - wrap pulses exactly once, on the 7 → 0 transition.
  - in_ready stays 0 throughout; in_valid during SCAN is ignored.
- Scan with dwell = 0: out advances every cycle. With 8 outputs, wrap pulses every 8 cycles.
- hold asserted for 4 cycles mid-dwell: the index does not change. The remaining dwell resumes exactly after hold is released.
- Abort and restart:
  - Drop mode while at index 3: out stays 8'b0000_1000 and in_ready rises next cycle.
  - A direct request with sel = 1 on the following edge gives out = 8'b0000_0010.
- Parameter and reset sweeps:
  - Assert rst_n low mid-scan asynchronously: out = 1 immediately, state = IDLE.
  - Repeat the suite with SEL_W = 1 and SEL_W = 4.
